// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// RegfileWriteArbiter (module regfile_write_arbiter)
//
// Purpose:
//   Owns the write side of a NUM_REGS x DATA_W register bank built from
//   register_32 instances. Two requesters share the bank:
//     requester 0 : pipeline writeback
//     requester 1 : multiply/divide unit
//   Accepted writes are turned into a registered one-hot enable plus a shared
//   data bus one cycle after the accepting edge. After reset, and whenever
//   flush is raised, every register is zero-filled, one register per cycle.
//   Register 0 is never enabled by a requester write, so MIPS $zero stays 0.
//
// Ports:
//   clock         system clock, rising edge active
//   clear_        synchronous active-low reset
//   flush         start / restart the zero-fill sequence
//   req0/addr0/data0, ack0   requester 0 handshake (ack is combinational)
//   req1/addr1/data1, ack1   requester 1 handshake (ack is combinational)
//   write_enable  one-hot (or zero) per-register enable, to register_32 enable
//   write_data    shared data bus, to register_32 parallel_in
//   busy          zero-fill in progress, no acks are issued
//   addr_err      one-cycle pulse in the strobe slot of an out-of-range write
//
// Configuration:
//   REGFILE_ARB_FIXED_PRI_EN  defined   -> requester 0 always wins a conflict
//                             undefined -> round-robin between requesters
// -----------------------------------------------------------------------------
module regfile_write_arbiter #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic                clock,
  input  logic                clear_,
  input  logic                flush,
  input  logic                req0,
  input  logic [ADDR_W-1:0]   addr0,
  input  logic [DATA_W-1:0]   data0,
  output logic                ack0,
  input  logic                req1,
  input  logic [ADDR_W-1:0]   addr1,
  input  logic [DATA_W-1:0]   data1,
  output logic                ack1,
  output logic [NUM_REGS-1:0] write_enable,
  output logic [DATA_W-1:0]   write_data,
  output logic                busy,
  output logic                addr_err
);

  typedef enum logic {
    FLUSH,
    RUN
  } stateT;

  localparam logic [ADDR_W-1:0]   LAST_IDX     = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W:0]     NUM_REGS_EXT = (ADDR_W+1)'(NUM_REGS);
  localparam logic [NUM_REGS-1:0] ONE_HOT_LSB  = NUM_REGS'(1);

  stateT               r_state;
  stateT               w_nextState;
  logic [ADDR_W-1:0]   r_count;
  logic [NUM_REGS-1:0] r_writeEnable;
  logic [DATA_W-1:0]   r_writeData;
  logic                r_addrErr;

  logic                w_accept;
  logic                w_pick1;
  logic                w_grant;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_data;
  logic                w_addrOutOfRange;
  logic                w_addrWritable;
  logic [NUM_REGS-1:0] w_addrOneHot;
  logic [NUM_REGS-1:0] w_countOneHot;

  // State register: reset always lands in FLUSH so the bank is zero-filled
  // before any requester is served.
  always_ff @(posedge clock) begin
    if (!clear_) begin
      r_state <= FLUSH;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: FLUSH leaves only once the last index has been issued
  // without a restart pending; a flush request in RUN always wins over writes.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      FLUSH: begin
        if (!flush && (r_count == LAST_IDX)) begin
          w_nextState = RUN;
        end
      end
      RUN: begin
        if (flush) begin
          w_nextState = FLUSH;
        end
      end
      default: w_nextState = FLUSH;
    endcase
  end

  // Output logic: acks are only offered in RUN when no flush is requested,
  // and at most one of them is high because w_pick1 selects a single winner.
  always_comb begin
    busy     = (r_state == FLUSH);
    w_accept = (r_state == RUN) && !flush;
    ack0     = w_accept && req0 && !w_pick1;
    ack1     = w_accept && w_pick1;
  end

`ifdef REGFILE_ARB_FIXED_PRI_EN
  // Fixed priority: requester 1 is picked only when requester 0 is idle,
  // so it can starve under continuous writeback traffic.
  always_comb begin
    w_pick1 = req1 && !req0;
  end
`else
  logic r_lastGrant;

  // Remember who won the most recent grant. Starting at 1 makes requester 0
  // the winner of the first conflict after reset.
  always_ff @(posedge clock) begin
    if (!clear_) begin
      r_lastGrant <= 1'b1;
    end else if (w_grant) begin
      r_lastGrant <= ack1;
    end
  end

  // Round-robin: requester 1 wins when it is alone, or when both request
  // and requester 0 took the previous grant.
  always_comb begin
    w_pick1 = req1 && (!req0 || !r_lastGrant);
  end
`endif

  // Winner's address/data selection and decode. Address 0 and addresses
  // past the bank are accepted but never produce an enable bit.
  always_comb begin
    w_grant          = ack0 || ack1;
    w_addr           = w_pick1 ? addr1 : addr0;
    w_data           = w_pick1 ? data1 : data0;
    w_addrOutOfRange = ({1'b0, w_addr} >= NUM_REGS_EXT);
    w_addrWritable   = (w_addr != '0) && !w_addrOutOfRange;
    w_addrOneHot     = ONE_HOT_LSB << w_addr;
    w_countOneHot    = ONE_HOT_LSB << r_count;
  end

  // Zero-fill counter: any flush request rewinds it to index 0, and it only
  // advances while the zero walk is running.
  always_ff @(posedge clock) begin
    if (!clear_) begin
      r_count <= '0;
    end else if (flush) begin
      r_count <= '0;
    end else if (r_state == FLUSH) begin
      r_count <= r_count + ADDR_W'(1);
    end
  end

  // Write strobe pipeline: everything presented to the bank is registered,
  // so a strobe appears exactly one cycle after the accepting edge. During
  // the walk the data bus is forced to zero; the cycle in which a restart is
  // requested issues no enable. Idle RUN cycles drop the enable but keep the
  // last data value on the bus.
  always_ff @(posedge clock) begin
    if (!clear_) begin
      r_writeEnable <= '0;
      r_writeData   <= '0;
      r_addrErr     <= 1'b0;
    end else if (r_state == FLUSH) begin
      r_writeData   <= '0;
      r_addrErr     <= 1'b0;
      r_writeEnable <= flush ? '0 : w_countOneHot;
    end else if (w_grant) begin
      r_writeData   <= w_data;
      r_writeEnable <= w_addrWritable ? w_addrOneHot : '0;
      r_addrErr     <= w_addrOutOfRange;
    end else begin
      r_writeEnable <= '0;
      r_addrErr     <= 1'b0;
    end
  end

  // Drive the bank-facing outputs straight from their registers.
  always_comb begin
    write_enable = r_writeEnable;
    write_data   = r_writeData;
    addr_err     = r_addrErr;
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// TbRegfileWriteArbiter (module tb_regfile_write_arbiter)
//
// Purpose:
//   Self-checking bench for regfile_write_arbiter with the default 32 x 32-bit
//   bank. A behavioural model tracks the flush walk, the arbitration winner
//   and the bank contents; every cycle the outputs are compared against it.
//   Directed scenarios pin the model with hand-computed values, then a long
//   randomized phase exercises requests, flushes and resets.
//
// Ports: none (top-level bench). Honours REGFILE_ARB_FIXED_PRI_EN.
// -----------------------------------------------------------------------------
module tb_regfile_write_arbiter;

  localparam int NUM = 32;

  logic        clock = 1'b0;
  logic        clear_ = 1'b0;
  logic        flush = 1'b0;
  logic        req0 = 1'b0;
  logic [4:0]  addr0 = '0;
  logic [31:0] data0 = '0;
  logic        req1 = 1'b0;
  logic [4:0]  addr1 = '0;
  logic [31:0] data1 = '0;
  logic        ack0;
  logic        ack1;
  logic [31:0] write_enable;
  logic [31:0] write_data;
  logic        busy;
  logic        addr_err;

  int testCount = 0;
  int failCount = 0;

  // Behavioural model state
  bit          mValid = 1'b0;
  bit          mFlushing;
  int          mIdx;
  int          mLast;
  int          mGrant;
  int          mAddr;
  logic [31:0] mWe = '0;
  logic [31:0] mWd = '0;
  logic        mErr = 1'b0;
  logic [31:0] mBank [NUM];
  logic [31:0] dutBank [NUM];
  int          cmpGrant;

  always #5 clock = ~clock;

  regfile_write_arbiter #(
    .NUM_REGS(32),
    .ADDR_W  (5),
    .DATA_W  (32)
  ) dut (
    .clock       (clock),
    .clear_      (clear_),
    .flush       (flush),
    .req0        (req0),
    .addr0       (addr0),
    .data0       (data0),
    .ack0        (ack0),
    .req1        (req1),
    .addr1       (addr1),
    .data1       (data1),
    .ack1        (ack1),
    .write_enable(write_enable),
    .write_data  (write_data),
    .busy        (busy),
    .addr_err    (addr_err)
  );

  // One comparison: count it, and report it when it does not hold.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
               name, actual, expected, $time);
    end
  endtask

  // Advance to just after the next rising edge, then drive all inputs.
  task automatic applyStimulus(input logic c, input logic f,
                               input logic r0, input logic [4:0] a0, input logic [31:0] d0,
                               input logic r1, input logic [4:0] a1, input logic [31:0] d1);
    @(posedge clock);
    #1;
    clear_ = c;
    flush  = f;
    req0   = r0;
    addr0  = a0;
    data0  = d0;
    req1   = r1;
    addr1  = a1;
    data1  = d1;
  endtask

  // Count busy cycles from the current cycle on, stopping at the first
  // non-busy negedge. A runaway walk is reported as a failure.
  task automatic waitIdle(output int busyCycles);
    busyCycles = 0;
    @(negedge clock);
    while (busy === 1'b1 && busyCycles < 200) begin
      busyCycles++;
      @(negedge clock);
    end
    if (busyCycles >= 200) checkOutput("flush_timeout", 32'(busyCycles), 32'd0);
  endtask

  // Arbitration rule: who is granted given the mode and the request lines.
  function automatic int pickGrant(input bit running, input bit f, input bit r0,
                                   input bit r1, input int last);
    if (!running || f) return -1;
    if (r0 && r1) begin
`ifdef REGFILE_ARB_FIXED_PRI_EN
      return 0;
`else
      return (last == 0) ? 1 : 0;
`endif
    end
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  // Model update on each rising edge: predicts the registered outputs that
  // the next cycle must show, and the bank contents after each write.
  always @(posedge clock) begin
    if (!clear_) begin
      mValid    = 1'b1;
      mFlushing = 1'b1;
      mIdx      = 0;
      mLast     = 1;
      mWe       = '0;
      mWd       = '0;
      mErr      = 1'b0;
    end else if (mValid) begin
      mGrant = pickGrant(!mFlushing, flush, req0, req1, mLast);
      mErr   = 1'b0;
      if (mFlushing) begin
        mWd = '0;
        if (flush) begin
          mIdx = 0;
          mWe  = '0;
        end else begin
          mWe         = 32'h1 << mIdx;
          mBank[mIdx] = '0;
          mIdx++;
          if (mIdx == NUM) mFlushing = 1'b0;
        end
      end else if (flush) begin
        mFlushing = 1'b1;
        mIdx      = 0;
        mWe       = '0;
      end else if (mGrant >= 0) begin
        mAddr = (mGrant == 1) ? int'(addr1) : int'(addr0);
        mWd   = (mGrant == 1) ? data1 : data0;
        mLast = mGrant;
        mErr  = (mAddr >= NUM);
        if (mAddr != 0 && mAddr < NUM) begin
          mWe          = 32'h1 << mAddr;
          mBank[mAddr] = mWd;
        end else begin
          mWe = '0;
        end
      end else begin
        mWe = '0;
      end
    end
  end

  // Compare process: every cycle after the first reset edge, all outputs
  // must match the model; the observed strobes also feed a shadow bank.
  always @(negedge clock) begin
    if (mValid) begin
      cmpGrant = pickGrant(!mFlushing, flush, req0, req1, mLast);
      checkOutput("ack0", 32'(ack0), 32'(cmpGrant == 0));
      checkOutput("ack1", 32'(ack1), 32'(cmpGrant == 1));
      checkOutput("busy", 32'(busy), 32'(mFlushing));
      checkOutput("write_enable", write_enable, mWe);
      checkOutput("write_data", write_data, mWd);
      checkOutput("addr_err", 32'(addr_err), 32'(mErr));
      for (int i = 0; i < NUM; i++) begin
        if (write_enable[i] === 1'b1) dutBank[i] = write_data;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          busyCycles;
    int          walkIdx;
    int          n;
    int          cyc;
    int          firstAt;
    int          lastAt;
    int          s;
    logic        ackWho [4];
    logic [31:0] strobeSeen [8];
    logic [31:0] expStrobe [4];
    logic        expWho [4];
    logic        a0;
    logic        a1;

    for (int i = 0; i < NUM; i++) begin
      mBank[i]   = '0;
      dutBank[i] = '0;
    end

    // Reset held for two edges, then the full zero walk.
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    busyCycles = 0;
    walkIdx    = 0;
    @(negedge clock);
    for (int k = 0; k < 200 && busy === 1'b1; k++) begin
      busyCycles++;
      if (write_enable !== 32'd0) begin
        checkOutput("reset_walk_bit", write_enable, 32'h1 << walkIdx);
        walkIdx++;
      end
      @(negedge clock);
    end
    checkOutput("reset_busy_cycles", 32'(busyCycles), 32'd32);
    checkOutput("reset_walk_count", 32'(walkIdx), 32'd31);
    checkOutput("reset_walk_last", write_enable, 32'h8000_0000);
    @(negedge clock);
    checkOutput("reset_idle_we", write_enable, 32'd0);

    // Single write to register 5.
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0);
    @(negedge clock);
    checkOutput("single_ack0", 32'(ack0), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clock);
    checkOutput("single_strobe_we", write_enable, 32'h0000_0020);
    checkOutput("single_strobe_wd", write_data, 32'hDEAD_BEEF);
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clock);
    checkOutput("single_after_we", write_enable, 32'd0);

    // Contention right after reset: both requesters held for four transfers.
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd1, 32'h1111_1111, 1'b1, 5'd2, 32'h2222_2222);
    n = 0; cyc = 0; s = 0; firstAt = 0; lastAt = 0;
    while (n < 4 && cyc < 200) begin
      @(negedge clock);
      cyc++;
      if (n > 0 && s < 8) begin
        strobeSeen[s] = write_enable;
        s++;
      end
      if (ack0 === 1'b1 || ack1 === 1'b1) begin
        ackWho[n] = ack1;
        if (n == 0) firstAt = cyc;
        lastAt = cyc;
        n++;
      end
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clock);
    if (s < 8) begin
      strobeSeen[s] = write_enable;
      s++;
    end
`ifdef REGFILE_ARB_FIXED_PRI_EN
    expWho    = '{1'b0, 1'b0, 1'b0, 1'b0};
    expStrobe = '{32'h2, 32'h2, 32'h2, 32'h2};
`else
    expWho    = '{1'b0, 1'b1, 1'b0, 1'b1};
    expStrobe = '{32'h2, 32'h4, 32'h2, 32'h4};
`endif
    checkOutput("contention_acks", 32'(n), 32'd4);
    checkOutput("contention_consecutive", 32'(lastAt - firstAt), 32'd3);
    checkOutput("contention_strobes", 32'(s), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < n) checkOutput($sformatf("contention_who[%0d]", i), 32'(ackWho[i]), 32'(expWho[i]));
      if (i < s) checkOutput($sformatf("contention_we[%0d]", i), strobeSeen[i], expStrobe[i]);
    end

    // Write to $zero is acked but never enabled.
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234_5678);
    @(negedge clock);
    checkOutput("zero_ack1", 32'(ack1), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clock);
    checkOutput("zero_we", write_enable, 32'd0);
    checkOutput("zero_err", 32'(addr_err), 32'd0);
    checkOutput("zero_wd", write_data, 32'h1234_5678);

    // Flush raised together with a request: flush wins, request waits.
    applyStimulus(1'b1, 1'b1, 1'b1, 5'd7, 32'hA5A5_A5A5, 1'b0, 5'd0, 32'd0);
    @(negedge clock);
    checkOutput("flushrun_ack0", 32'(ack0), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd7, 32'hA5A5_A5A5, 1'b0, 5'd0, 32'd0);
    waitIdle(busyCycles);
    checkOutput("flushrun_busy_cycles", 32'(busyCycles), 32'd32);
    checkOutput("flushrun_ack0_after", 32'(ack0), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    // Flush again while the walk sits at index 10: restart from bit 0.
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clock);
    checkOutput("restart_we_before", write_enable, 32'h0000_0200);
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clock);
    checkOutput("restart_we_gap", write_enable, 32'd0);
    checkOutput("restart_busy", 32'(busy), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clock);
    checkOutput("restart_we_bit0", write_enable, 32'h0000_0001);
    waitIdle(busyCycles);
    checkOutput("restart_tail_busy", 32'(busyCycles), 32'd30);

    // Reset while the walk sits at index 17.
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 17; i++) applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clock);
    checkOutput("midreset_we_before", write_enable, 32'h0001_0000);
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clock);
    checkOutput("midreset_we", write_enable, 32'd0);
    checkOutput("midreset_busy", 32'(busy), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clock);
    checkOutput("midreset_we_bit0", write_enable, 32'h0000_0001);
    waitIdle(busyCycles);
    checkOutput("midreset_tail_busy", 32'(busyCycles), 32'd30);

    // Randomized traffic: requesters hold until acked, occasional flush and
    // reset pulses. The compare process checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      a0 = ack0 && clear_;
      a1 = ack1 && clear_;
      @(posedge clock);
      #1;
      if (!req0 || a0) begin
        req0  = ($urandom_range(0, 3) != 0);
        addr0 = 5'($urandom_range(0, 31));
        data0 = $urandom;
      end
      if (!req1 || a1) begin
        req1  = ($urandom_range(0, 3) != 0);
        addr1 = 5'($urandom_range(0, 31));
        data1 = $urandom;
      end
      flush  = ($urandom_range(0, 99) == 0);
      clear_ = ($urandom_range(0, 499) != 0);
    end

    // Drain and compare the bank contents seen on the bus with the model.
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    waitIdle(busyCycles);
    @(negedge clock);
    @(negedge clock);
    for (int i = 0; i < NUM; i++) begin
      checkOutput($sformatf("bank[%0d]", i), dutBank[i], mBank[i]);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
